// File: rtl/display_driver_gen_if.sv
// Bus bundle for the seven-segment display controller: ALU-side inputs in,
// segment bus and conversion status out.
interface display_driver_gen_if #(
   parameter int unsigned RES_W      = 16,
   parameter int unsigned NUM_DIGITS = 6
);
   logic                    oneMsPulse;
   logic [1:0]              dispMode;
   logic [7:0]              OpReg;
   logic                    ShowOpReg;
   logic [2:0]              OpCode;
   logic                    ShowOpCode;
   logic [RES_W-1:0]        OpResult;
   logic [8*NUM_DIGITS-1:0] HEX;
   logic                    convBusy;

   modport master (
      output oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult,
      input  HEX, convBusy
   );

   modport slave (
      input  oneMsPulse, dispMode, OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult,
      output HEX, convBusy
   );
endinterface

// File: rtl/display_driver_gen.sv
// Seven-segment display controller: shows the ALU result as unsigned decimal,
// signed decimal or hex, with timed 'rEg ##' / 'CoDE #' overlays. Decimal
// digits come from a sequential subtract-by-power-of-ten converter whose result
// is only published on completion.
module display_driver_gen #(
   parameter int unsigned RES_W      = 16,
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned HOLD_MS    = 3000
) (
   input logic                clk,
   input logic                rst_n,
   display_driver_gen_if.slave bus
);

   function automatic int unsigned dec_digits(input int unsigned w);
      longint unsigned v;
      int unsigned     n;
      v = (64'd1 << w) - 64'd1;
      n = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (v != 0) begin
            v = v / 10;
            n++;
         end
      end
      return n;
   endfunction

   function automatic longint unsigned pow10(input int unsigned k);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   localparam int unsigned D  = dec_digits(RES_W);
   localparam int unsigned KW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned HN = (RES_W + 3) / 4;
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

   localparam logic [4:0] CH_R     = 5'h10;
   localparam logic [4:0] CH_O     = 5'h11;
   localparam logic [4:0] CH_G     = 5'h12;
   localparam logic [4:0] CH_BLANK = 5'h13;
   localparam logic [4:0] CH_MINUS = 5'h14;

   typedef enum logic [1:0] {OV_RESULT, OV_OPREG, OV_OPCODE} ov_state_e;
   typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_DIGIT, CV_COMMIT} cv_state_e;

   ov_state_e              ov_q, ov_d;
   logic [15:0]            ms_cnt_q, ms_cnt_d;
   cv_state_e              cv_q, cv_d;
   logic [KW-1:0]          k_q, k_d;
   logic [RES_W-1:0]       mag_q, mag_d;
   logic [RES_W:0]         src_q, src_d;
   logic [D-1:0][3:0]      work_q, work_d;
   logic                   neg_q, neg_d;
   logic [D-1:0][3:0]      dec_disp_q, dec_disp_d;
   logic                   neg_flag_q, neg_flag_d;
   logic                   valid_q, valid_d;
   logic                   conv_busy_q, conv_busy_d;

   logic [RES_W-1:0]       p10 [D];
   logic [RES_W:0]         src_now;
   logic                   sgn_now;
   logic [NUM_DIGITS-1:0][3:0] dwide;
   logic [NUM_DIGITS-1:0][3:0] hwide;
   logic [NUM_DIGITS-1:0]  shown;
   logic [NUM_DIGITS-1:0]  minus_pos;
   logic [NUM_DIGITS-1:0][4:0] ch;
   logic [NUM_DIGITS-1:0][7:0] seg;

   for (genvar g = 0; g < D; g++) begin : g_p10
      assign p10[g] = RES_W'(pow10(g));
   end

   assign sgn_now = (bus.dispMode == 2'd2);
   assign src_now = {bus.OpResult, sgn_now};
   assign dwide   = (4*NUM_DIGITS)'(dec_disp_q);
   assign hwide   = (4*NUM_DIGITS)'(bus.OpResult);

   // Overlay selection and millisecond hold counter; OPCODE wins on simultaneous pulses
   always_comb begin
      ov_d     = ov_q;
      ms_cnt_d = ms_cnt_q;
      case (ov_q)
         OV_RESULT: begin
            if (bus.ShowOpCode) begin
               ov_d     = OV_OPCODE;
               ms_cnt_d = '0;
            end else if (bus.ShowOpReg) begin
               ov_d     = OV_OPREG;
               ms_cnt_d = '0;
            end
         end
         default: begin
            if (bus.ShowOpCode || bus.ShowOpReg) begin
               ov_d     = bus.ShowOpCode ? OV_OPCODE : OV_OPREG;
               ms_cnt_d = '0;
            end else if (bus.oneMsPulse) begin
               if (ms_cnt_q == HOLD_LAST) begin
                  ov_d     = OV_RESULT;
                  ms_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_cnt_q + 16'd1;
               end
            end
         end
      endcase
   end

   // Decimal conversion: one subtraction or one digit step per cycle, aborted on source change
   always_comb begin
      cv_d       = cv_q;
      k_d        = k_q;
      mag_d      = mag_q;
      src_d      = src_q;
      work_d     = work_q;
      neg_d      = neg_q;
      dec_disp_d = dec_disp_q;
      neg_flag_d = neg_flag_q;
      valid_d    = valid_q;
      case (cv_q)
         CV_IDLE: begin
            if ((src_now != src_q) || !valid_q) cv_d = CV_LOAD;
         end
         CV_LOAD: begin
            src_d  = src_now;
            neg_d  = sgn_now && bus.OpResult[RES_W-1];
            // Negating the most negative value yields 2^(RES_W-1), still correct read as unsigned
            mag_d  = (sgn_now && bus.OpResult[RES_W-1]) ? -bus.OpResult : bus.OpResult;
            work_d = '0;
            k_d    = KW'(D - 1);
            cv_d   = CV_DIGIT;
         end
         CV_DIGIT: begin
            if (src_now != src_q) begin
               cv_d = CV_LOAD;
            end else if (mag_q >= p10[k_q]) begin
               mag_d       = mag_q - p10[k_q];
               work_d[k_q] = work_q[k_q] + 4'd1;
            end else if (k_q == '0) begin
               cv_d = CV_COMMIT;
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         default: begin
            dec_disp_d = work_q;
            neg_flag_d = neg_q;
            valid_d    = 1'b1;
            cv_d       = CV_IDLE;
         end
      endcase
      conv_busy_d = (cv_d != CV_IDLE);
   end

   // State registers for both FSMs and the committed display buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q        <= OV_RESULT;
         ms_cnt_q    <= '0;
         cv_q        <= CV_IDLE;
         k_q         <= '0;
         mag_q       <= '0;
         src_q       <= '0;
         work_q      <= '0;
         neg_q       <= 1'b0;
         dec_disp_q  <= '0;
         neg_flag_q  <= 1'b0;
         valid_q     <= 1'b0;
         conv_busy_q <= 1'b0;
      end else begin
         ov_q        <= ov_d;
         ms_cnt_q    <= ms_cnt_d;
         cv_q        <= cv_d;
         k_q         <= k_d;
         mag_q       <= mag_d;
         src_q       <= src_d;
         work_q      <= work_d;
         neg_q       <= neg_d;
         dec_disp_q  <= dec_disp_d;
         neg_flag_q  <= neg_flag_d;
         valid_q     <= valid_d;
         conv_busy_q <= conv_busy_d;
      end
   end

   // Leading-zero blanking mask and minus position just left of the top shown digit
   always_comb begin
      logic        acc;
      int unsigned idx;
      acc   = 1'b0;
      idx   = 0;
      shown = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         idx        = NUM_DIGITS - 1 - j;
         acc        = acc | (dwide[idx] != 4'd0);
         shown[idx] = acc;
      end
      shown[0]  = 1'b1;
      minus_pos = neg_flag_q ? ((shown << 1) & ~shown) : '0;
   end

   // Character selection per digit for overlays, hex and decimal views
   always_comb begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         ch[i] = CH_BLANK;
         case (ov_q)
            OV_OPREG: begin
               case (i)
                  5: ch[i] = CH_R;
                  4: ch[i] = 5'h0E;
                  3: ch[i] = CH_G;
                  1: ch[i] = {1'b0, bus.OpReg[7:4]};
                  0: ch[i] = {1'b0, bus.OpReg[3:0]};
                  default: ch[i] = CH_BLANK;
               endcase
            end
            OV_OPCODE: begin
               case (i)
                  5: ch[i] = 5'h0C;
                  4: ch[i] = CH_O;
                  3: ch[i] = 5'h0D;
                  2: ch[i] = 5'h0E;
                  0: ch[i] = {2'b00, bus.OpCode};
                  default: ch[i] = CH_BLANK;
               endcase
            end
            default: begin
               if (bus.dispMode == 2'd1) begin
                  if (i < HN) ch[i] = {1'b0, hwide[i]};
               end else if (shown[i]) begin
                  ch[i] = {1'b0, dwide[i]};
               end else if (minus_pos[i]) begin
                  ch[i] = CH_MINUS;
               end
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_driver u_hex (
         .ch  (ch[g]),
         .seg (seg[g])
      );
   end

   assign bus.HEX      = seg;
   assign bus.convBusy = conv_busy_q;

endmodule

// Character-to-segment decoder, active-low {dp,g,f,e,d,c,b,a}, dp always off.
module hex_driver (
   input  logic [4:0] ch,
   output logic [7:0] seg
);
   // Glyph lookup; unknown codes render blank
   always_comb begin
      seg = 8'hFF;
      case (ch)
         5'h00: seg = 8'hC0;
         5'h01: seg = 8'hF9;
         5'h02: seg = 8'hA4;
         5'h03: seg = 8'hB0;
         5'h04: seg = 8'h99;
         5'h05: seg = 8'h92;
         5'h06: seg = 8'h82;
         5'h07: seg = 8'hF8;
         5'h08: seg = 8'h80;
         5'h09: seg = 8'h90;
         5'h0A: seg = 8'h88;
         5'h0B: seg = 8'h83;
         5'h0C: seg = 8'hC6;
         5'h0D: seg = 8'hA1;
         5'h0E: seg = 8'h86;
         5'h0F: seg = 8'h8E;
         5'h10: seg = 8'hAF;
         5'h11: seg = 8'hA3;
         5'h12: seg = 8'h90;
         5'h14: seg = 8'hBF;
         default: seg = 8'hFF;
      endcase
   end
endmodule
